// File: rtl/multi_cycle_control_pkg.sv
// Shared CPU definitions: FSM state encodings, opcodes and ALU operation codes.
// Reused by the control unit, the datapath and the benches.
package multi_cycle_control_pkg;

  typedef enum logic [2:0] {
    stIf   = 3'b000,
    stId   = 3'b001,
    stExe  = 3'b010,
    stExb  = 3'b011,
    stMem  = 3'b100,
    stWb   = 3'b101,
    stHalt = 3'b111
  } stateT;

  localparam logic [5:0] opAdd  = 6'b000000;
  localparam logic [5:0] opAddi = 6'b000001;
  localparam logic [5:0] opSub  = 6'b000010;
  localparam logic [5:0] opOri  = 6'b010000;
  localparam logic [5:0] opAnd  = 6'b010001;
  localparam logic [5:0] opOr   = 6'b010010;
  localparam logic [5:0] opSw   = 6'b100110;
  localparam logic [5:0] opLw   = 6'b100111;
  localparam logic [5:0] opBeq  = 6'b110000;
  localparam logic [5:0] opHalt = 6'b111111;

  localparam logic [2:0] aluAdd = 3'b000;
  localparam logic [2:0] aluSub = 3'b001;
  localparam logic [2:0] aluOr  = 3'b011;
  localparam logic [2:0] aluAnd = 3'b100;

  // Anything outside the supported instruction set retires as a no-op.
  function automatic logic isNop(input logic [5:0] op);
    case (op)
      opAdd, opAddi, opSub, opOri, opAnd, opOr,
      opSw, opLw, opBeq, opHalt: return 1'b0;
      default:                   return 1'b1;
    endcase
  endfunction

  function automatic logic isRType(input logic [5:0] op);
    return (op == opAdd) || (op == opSub) || (op == opAnd) || (op == opOr);
  endfunction

  function automatic logic [2:0] aluOpFor(input logic [5:0] op);
    case (op)
      opSub, opBeq: return aluSub;
      opOr, opOri:  return aluOr;
      opAnd:        return aluAnd;
      default:      return aluAdd;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control-unit to datapath bundle: instruction/flag inputs and all control outputs.
interface multi_cycle_control_if;
  logic [5:0]  opcode;
  logic        zero;
  logic        PCWre;
  logic        IRWre;
  logic        ALUSrcB;
  logic        ALUM2Reg;
  logic        RegWre;
  logic        DataMemRW;
  logic        ExtSel;
  logic        PCSrc;
  logic        RegOut;
  logic [2:0]  ALUOp;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] retired;

  modport master (
    output opcode, zero,
    input  PCWre, IRWre, ALUSrcB, ALUM2Reg, RegWre, DataMemRW, ExtSel,
           PCSrc, RegOut, ALUOp, state, halted, retired
  );

  modport slave (
    input  opcode, zero,
    output PCWre, IRWre, ALUSrcB, ALUM2Reg, RegWre, DataMemRW, ExtSel,
           PCSrc, RegOut, ALUOp, state, halted, retired
  );
endinterface

// File: rtl/control_decode.sv
// Combinational map from (state, opcode, zero) to datapath control signals.
module control_decode
  import multi_cycle_control_pkg::*;
(
  input  stateT      state,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pcWre,
  output logic       irWre,
  output logic       aluSrcB,
  output logic       aluM2Reg,
  output logic       regWre,
  output logic       dataMemRW,
  output logic       extSel,
  output logic       pcSrc,
  output logic       regOut,
  output logic [2:0] aluOp,
  output logic       halted
);

  always_comb begin
    pcWre     = 1'b0;
    irWre     = 1'b0;
    aluSrcB   = 1'b0;
    aluM2Reg  = 1'b0;
    regWre    = 1'b0;
    dataMemRW = 1'b0;
    extSel    = 1'b0;
    pcSrc     = 1'b0;
    regOut    = 1'b0;
    aluOp     = aluAdd;
    halted    = 1'b0;
    case (state)
      stIf:   irWre = 1'b1;
      stHalt: halted = 1'b1;
      default: begin
        aluSrcB   = (opcode == opAddi) || (opcode == opOri) ||
                    (opcode == opSw)   || (opcode == opLw);
        aluM2Reg  = (opcode == opLw);
        regOut    = isRType(opcode);
        extSel    = (opcode != opOri);
        aluOp     = aluOpFor(opcode);
        regWre    = (state == stWb);
        dataMemRW = (state == stMem) && (opcode == opSw);
        pcSrc     = (state == stExb) && zero;
        // PC advances once, in whichever state finishes the instruction.
        pcWre     = (state == stWb) || (state == stExb) ||
                    ((state == stMem) && (opcode == opSw)) ||
                    ((state == stId) && isNop(opcode));
      end
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control unit: instruction FSM, opcode latch and retire counter.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multi_cycle_control_if.slave bus
);

  stateT       state;
  stateT       decState;
  logic [5:0]  opReg;
  logic [5:0]  decOp;
  logic [15:0] retired;
  logic        pcWre;

  // Reset forces fetch-state outputs even before the synchronous reset lands.
  assign decState = reset ? stIf : state;
  // The instruction register holds the new opcode during ID; it is latched at the end of ID.
  assign decOp    = (state == stId) ? bus.opcode : opReg;

  control_decode uDecode (
    .state     (decState),
    .opcode    (decOp),
    .zero      (bus.zero),
    .pcWre     (pcWre),
    .irWre     (bus.IRWre),
    .aluSrcB   (bus.ALUSrcB),
    .aluM2Reg  (bus.ALUM2Reg),
    .regWre    (bus.RegWre),
    .dataMemRW (bus.DataMemRW),
    .extSel    (bus.ExtSel),
    .pcSrc     (bus.PCSrc),
    .regOut    (bus.RegOut),
    .aluOp     (bus.ALUOp),
    .halted    (bus.halted)
  );

  assign bus.PCWre   = pcWre;
  assign bus.state   = state;
  assign bus.retired = retired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= stIf;
      opReg   <= '0;
      retired <= '0;
    end else begin
      if (pcWre) retired <= retired + 16'd1;
      case (state)
        stIf: state <= stId;
        stId: begin
          opReg <= bus.opcode;
          if (bus.opcode == opBeq)       state <= stExb;
          else if (bus.opcode == opHalt) state <= stHalt;
          else if (isNop(bus.opcode))    state <= stIf;
          else                           state <= stExe;
        end
        stExe:  state <= ((opReg == opSw) || (opReg == opLw)) ? stMem : stWb;
        stMem:  state <= (opReg == opLw) ? stWb : stIf;
        stWb:   state <= stIf;
        stExb:  state <= stIf;
        stHalt: state <= stHalt;
        default: state <= stIf;
      endcase
    end
  end

endmodule
